top_cpu: RTL and testbench
==========================

Name:
top_cpu

Overview:
- Single-issue 16-bit execute/writeback slice of the CPU datapath.
- A 4-bit opcode demultiplexes the operands to one of five functional units: arithmetic, multiply/divide, logic, shift, compare.
- A 2-bit function select f0 picks the sub-operation inside that unit.
- The result appears combinationally on out and is registered one cycle later on out_wb, which drives the register-file write port.

Parameters:
- WIDTH, 16, operand/result width. All behaviour and test values below are specified for 16.

Ports:
- clk  input  1  system clock; out_wb updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- f0  input  2  function select within the chosen unit.
- opcode  input  4  functional-unit select.
- inp1  input  WIDTH  operand A, two's complement.
- inp2  input  WIDTH  operand B, two's complement.
- cin  input  1  carry-in, used by ADD only.
- bin  input  1  borrow-in, used by SUB only.
- out  output  WIDTH  combinational execute result.
- out_wb  output  WIDTH  registered writeback result.
- Connect ports by name. The legacy positional order (f0, opcode, inp1, inp2, cin, bin, out, out_wb) is not supported once clk/rst are added.

Behaviour:
- Reset: one clock; reset is synchronous and active-high. With rst high at a rising clk edge, out_wb <= 0. out stays purely combinational and is unaffected by rst.
- Writeback: each rising clk edge with rst low does out_wb <= out.
  - Latency: out = 0 cycles; out_wb = 1 cycle.
  - No handshake: every cycle is a valid issue.
- Result width: all results are truncated to WIDTH bits. Signed arithmetic is used wherever noted.
- opcode 0000, arithmetic:
  - f0=00: inp1+inp2+cin.
  - f0=01: inp1-inp2-bin.
  - f0=10: inp1+1.
  - f0=11: inp1-1.
  - All wrap modulo 2^16.
- opcode 0001, multiply/divide (signed):
  - f0=00: low 16 bits of the 32-bit signed product.
  - f0=01: signed quotient, truncated toward zero.
  - f0=10: signed remainder; sign follows the dividend.
  - f0=11: high 16 bits of the 32-bit signed product.
  - inp2=0: quotient = 16'hFFFF, remainder = inp1.
  - -32768 / -1: quotient = -32768, remainder = 0.
- opcode 0010, logic:
  - f0=00: AND.
  - f0=01: OR.
  - f0=10: XOR.
  - f0=11: bitwise NOT of inp1.
- opcode 0011, shift. Shift amount is inp2[3:0]; upper bits of inp2 are ignored.
  - f0=00: logical left.
  - f0=01: logical right.
  - f0=10: arithmetic right.
  - f0=11: rotate left.
  - Amount 0 returns inp1 unchanged.
- opcode 0100, compare:
  - f0=00: 1 if inp1==inp2, else 0.
  - f0=01: 1 if inp1<inp2 (signed), else 0.
  - f0=10: 1 if inp1<inp2 (unsigned), else 0.
  - f0=11: signed max(inp1, inp2).
- opcodes 0101..1111: out = 0; out_wb captures 0 on the next edge.
- Input changes mid-cycle propagate to out immediately. out_wb reflects only the value of out sampled at the edge.

Optional Feature:
- Macro TOP_CPU_FLAGS_EN.
- Defined:
  - Adds output flags_wb [3:0] = {Z, N, C, V}, registered alongside out_wb and cleared to 0 by rst.
  - Z = (out==0); N = out[15].
  - C = carry-out for ADD/INC, or borrow for SUB/DEC; otherwise 0.
  - V = signed overflow for the arithmetic unit, or for multiply when the product does not fit in 16 signed bits; otherwise 0.
- Not defined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset: hold rst high for 2 edges with any inputs -> out_wb=0. Release rst with opcode=0001, f0=00, inp1=120, inp2=10 -> out=1200 immediately; out_wb=1200 after 1 edge.
- Mul/div sweep with inp1=120, inp2=10, cin=bin=0, opcode=0001:
  - f0=00 -> 1200
  - f0=01 -> 12
  - f0=10 -> 0
  - f0=11 -> 0
  - Each value must appear on out_wb one edge later.
- Signed/edge cases, opcode=0001:
  - inp1=-300, inp2=200, f0=00 -> -60000 truncated = 5536; f0=11 -> -1.
  - inp1=-7, inp2=2 -> quotient -3, remainder -1.
  - inp2=0 -> quotient 16'hFFFF, remainder = inp1.
- Arithmetic, opcode=0000:
  - inp1=32767, inp2=0, cin=1, f0=00 -> -32768 (with TOP_CPU_FLAGS_EN: V=1, N=1).
  - inp1=120, inp2=10, bin=1, f0=01 -> 109.
- Logic/shift/compare with inp1=120, inp2=10:
  - AND -> 8; XOR -> 114.
  - SLL -> 0xE000 (= -8192).
  - SRA of inp1=-128 by 10 -> -1.
  - signed lt -> 0; max -> 120.
- Unused opcode 1010 with nonzero operands -> out=0; out_wb=0 next edge. Asserting rst on the same edge as a valid result -> out_wb=0.

Source files
------------

// File: rtl/top_cpu.sv
// rtl/top_cpu.sv - 16-bit execute/writeback slice: arith, mul/div, logic, shift, compare units
// Optional feature macro: TOP_CPU_FLAGS_EN adds registered {Z,N,C,V} flags on flags_wb.
module top_cpu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       f0,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] inp1,
    input  logic [WIDTH-1:0] inp2,
    input  logic             cin,
    input  logic             bin,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_wb
`ifdef TOP_CPU_FLAGS_EN
    ,
    output logic [3:0]       flags_wb
`endif
);

    localparam logic [3:0] OP_ARITH  = 4'b0000;
    localparam logic [3:0] OP_MULDIV = 4'b0001;
    localparam logic [3:0] OP_LOGIC  = 4'b0010;
    localparam logic [3:0] OP_SHIFT  = 4'b0011;
    localparam logic [3:0] OP_CMP    = 4'b0100;

    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [4:0]       W5      = 5'(WIDTH);

    logic signed [WIDTH-1:0]   a_s;
    logic signed [WIDTH-1:0]   b_s;
    logic signed [2*WIDTH-1:0] prod;
    logic                      div_by_zero;
    logic                      div_ovf;
    logic signed [WIDTH-1:0]   div_b;
    logic signed [WIDTH-1:0]   quo_s;
    logic signed [WIDTH-1:0]   rem_s;
    logic [WIDTH-1:0]          quo;
    logic [WIDTH-1:0]          rem;
    logic [3:0]                sh;
    logic [4:0]                rot_back;
    logic [WIDTH-1:0]          cin_ext;
    logic [WIDTH-1:0]          bin_ext;

    assign a_s     = $signed(inp1);
    assign b_s     = $signed(inp2);
    assign sh      = inp2[3:0];
    assign rot_back = W5 - {1'b0, sh};
    assign cin_ext = {{(WIDTH-1){1'b0}}, cin};
    assign bin_ext = {{(WIDTH-1){1'b0}}, bin};

    // Full signed product from explicitly sign-extended operands
    assign prod = $signed({{WIDTH{inp1[WIDTH-1]}}, inp1}) * $signed({{WIDTH{inp2[WIDTH-1]}}, inp2});

    // Divide-by-zero and MIN/-1 both divide by 1 so the divider never sees an illegal case;
    // MIN/1 already yields quotient MIN and remainder 0, divide-by-zero is overridden below.
    assign div_by_zero = (inp2 == '0);
    assign div_ovf     = (inp1 == MIN_NEG) && (inp2 == '1);
    assign div_b       = (div_by_zero || div_ovf) ? $signed(ONE) : b_s;
    assign quo_s       = a_s / div_b;
    assign rem_s       = a_s % div_b;
    assign quo         = div_by_zero ? '1 : quo_s;
    assign rem         = div_by_zero ? inp1 : rem_s;

    // Execute: demultiplex on opcode, pick the sub-operation with f0
    always_comb begin
        out = '0;
        case (opcode)
            OP_ARITH: begin
                case (f0)
                    2'b00: out = inp1 + inp2 + cin_ext;
                    2'b01: out = inp1 - inp2 - bin_ext;
                    2'b10: out = inp1 + ONE;
                    2'b11: out = inp1 - ONE;
                endcase
            end
            OP_MULDIV: begin
                case (f0)
                    2'b00: out = prod[WIDTH-1:0];
                    2'b01: out = quo;
                    2'b10: out = rem;
                    2'b11: out = prod[2*WIDTH-1:WIDTH];
                endcase
            end
            OP_LOGIC: begin
                case (f0)
                    2'b00: out = inp1 & inp2;
                    2'b01: out = inp1 | inp2;
                    2'b10: out = inp1 ^ inp2;
                    2'b11: out = ~inp1;
                endcase
            end
            OP_SHIFT: begin
                case (f0)
                    2'b00: out = inp1 << sh;
                    2'b01: out = inp1 >> sh;
                    2'b10: out = a_s >>> sh;
                    2'b11: out = (inp1 << sh) | (inp1 >> rot_back);
                endcase
            end
            OP_CMP: begin
                case (f0)
                    2'b00: out = {{(WIDTH-1){1'b0}}, inp1 == inp2};
                    2'b01: out = {{(WIDTH-1){1'b0}}, a_s < b_s};
                    2'b10: out = {{(WIDTH-1){1'b0}}, inp1 < inp2};
                    2'b11: out = (a_s < b_s) ? inp2 : inp1;
                endcase
            end
            default: out = '0;
        endcase
    end

`ifdef TOP_CPU_FLAGS_EN
    logic [3:0] flags_next;
    logic       msb_a;
    logic       msb_b;
    logic       msb_r;
    logic       mul_fits;

    assign msb_a    = inp1[WIDTH-1];
    assign msb_b    = inp2[WIDTH-1];
    assign msb_r    = out[WIDTH-1];
    assign mul_fits = (prod[2*WIDTH-1:WIDTH-1] == '0) || (prod[2*WIDTH-1:WIDTH-1] == '1);

    // Flags derived from the MSBs of operands and result; carry/borrow only for the arithmetic unit
    always_comb begin
        flags_next    = 4'b0000;
        flags_next[3] = (out == '0);
        flags_next[2] = msb_r;
        if (opcode == OP_ARITH) begin
            case (f0)
                2'b00: begin
                    flags_next[1] = (msb_a & msb_b) | ((msb_a | msb_b) & ~msb_r);
                    flags_next[0] = (msb_a == msb_b) && (msb_r != msb_a);
                end
                2'b01: begin
                    flags_next[1] = (~msb_a & msb_b) | ((~msb_a | msb_b) & msb_r);
                    flags_next[0] = (msb_a != msb_b) && (msb_r != msb_a);
                end
                2'b10: begin
                    flags_next[1] = (inp1 == '1);
                    flags_next[0] = (inp1 == MAX_POS);
                end
                2'b11: begin
                    flags_next[1] = (inp1 == '0);
                    flags_next[0] = (inp1 == MIN_NEG);
                end
            endcase
        end else if (opcode == OP_MULDIV && (f0 == 2'b00 || f0 == 2'b11)) begin
            flags_next[0] = ~mul_fits;
        end
    end

    // Flags register alongside the writeback result
    always_ff @(posedge clk) begin
        if (rst) flags_wb <= 4'b0000;
        else     flags_wb <= flags_next;
    end
`endif

    // Writeback register feeding the register-file write port
    always_ff @(posedge clk) begin
        if (rst) out_wb <= '0;
        else     out_wb <= out;
    end

endmodule

// File: tb/tb_top_cpu.sv
// tb/tb_top_cpu.sv - scoreboard bench for top_cpu with randomized stimulus and reference model
module tb_top_cpu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  f0 = 2'b00;
    logic [3:0]  opcode = 4'b0000;
    logic [15:0] inp1 = 16'h0;
    logic [15:0] inp2 = 16'h0;
    logic        cin = 1'b0;
    logic        bin = 1'b0;
    logic [15:0] out;
    logic [15:0] out_wb;
`ifdef TOP_CPU_FLAGS_EN
    logic [3:0]  flags_wb;
`endif

    top_cpu #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .f0(f0), .opcode(opcode),
        .inp1(inp1), .inp2(inp2), .cin(cin), .bin(bin),
        .out(out), .out_wb(out_wb)
`ifdef TOP_CPU_FLAGS_EN
        , .flags_wb(flags_wb)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] exp_out;
        logic [15:0] exp_wb;
        logic [3:0]  exp_flags;
        string       tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: integer arithmetic straight from the operation definitions. Returns {flags, result}.
    function automatic logic [19:0] model(input logic [3:0] op, input logic [1:0] f,
                                          input logic [15:0] a, input logic [15:0] b,
                                          input logic ci, input logic bi);
        int as = $signed(a);
        int bs = $signed(b);
        int au = a;
        int bu = b;
        int cii = ci;
        int bii = bi;
        int r = 0;
        int n = b[3:0];
        bit c = 0;
        bit v = 0;
        logic [15:0] res;
        case (op)
            4'd0: begin
                case (f)
                    2'd0: begin r = as + bs + cii; c = (au + bu + cii) > 65535; end
                    2'd1: begin r = as - bs - bii; c = (au - bu - bii) < 0; end
                    2'd2: begin r = as + 1; c = (au == 65535); end
                    default: begin r = as - 1; c = (au == 0); end
                endcase
                v = (r > 32767) || (r < -32768);
            end
            4'd1: begin
                case (f)
                    2'd0: begin r = as * bs; v = (r > 32767) || (r < -32768); end
                    2'd1: r = (bs == 0) ? 65535 : as / bs;
                    2'd2: r = (bs == 0) ? au : as % bs;
                    default: begin r = (as * bs) >>> 16; v = ((as * bs) > 32767) || ((as * bs) < -32768); end
                endcase
            end
            4'd2: begin
                case (f)
                    2'd0: r = au & bu;
                    2'd1: r = au | bu;
                    2'd2: r = au ^ bu;
                    default: r = ~au;
                endcase
            end
            4'd3: begin
                case (f)
                    2'd0: r = au << n;
                    2'd1: r = au >> n;
                    2'd2: r = as >>> n;
                    default: r = (au << n) | (au >> (16 - n));
                endcase
            end
            4'd4: begin
                case (f)
                    2'd0: r = (au == bu) ? 1 : 0;
                    2'd1: r = (as < bs) ? 1 : 0;
                    2'd2: r = (au < bu) ? 1 : 0;
                    default: r = (as < bs) ? bs : as;
                endcase
            end
            default: r = 0;
        endcase
        res = 16'(r);
        return {res == 16'h0, res[15], c, v, res};
    endfunction

    // Drive one issue slot just after the edge and push what the DUT owes us
    task automatic issue(input logic r_, input logic [3:0] op, input logic [1:0] f,
                         input logic [15:0] a, input logic [15:0] b, input logic ci, input logic bi,
                         input string tag, input bit use_k = 1'b0, input logic [15:0] k = 16'h0);
        logic [19:0] m;
        exp_t e;
        @(posedge clk);
        #1;
        rst = r_; opcode = op; f0 = f; inp1 = a; inp2 = b; cin = ci; bin = bi;
        m = model(op, f, a, b, ci, bi);
        e.exp_out   = use_k ? k : m[15:0];
        e.exp_wb    = r_ ? 16'h0 : e.exp_out;
        e.exp_flags = r_ ? 4'h0 : m[19:16];
        e.tag       = tag;
        sb_q.push_back(e);
    endtask

    function automatic logic [15:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'h0001;
            2: return 16'hFFFF;
            3: return 16'h8000;
            4: return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // Monitor: out_wb of the previous slot, then out of the slot now on the inputs
    exp_t pend;
    bit   have_pend = 1'b0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (have_pend) begin
                check({pend.tag, " out_wb"}, out_wb, pend.exp_wb);
`ifdef TOP_CPU_FLAGS_EN
                check({pend.tag, " flags_wb"}, {12'h0, flags_wb}, {12'h0, pend.exp_flags});
`endif
                have_pend = 1'b0;
            end
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check({e.tag, " out"}, out, e.exp_out);
                pend = e;
                have_pend = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d pending", sb_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        issue(1, 4'd1, 2'd0, 16'd120, 16'd10, 0, 0, "reset0");
        issue(1, 4'd1, 2'd0, 16'd120, 16'd10, 0, 0, "reset1");
        issue(0, 4'd1, 2'd0, 16'd120, 16'd10, 0, 0, "mul_release", 1, 16'd1200);
        issue(0, 4'd1, 2'd1, 16'd120, 16'd10, 0, 0, "div", 1, 16'd12);
        issue(0, 4'd1, 2'd2, 16'd120, 16'd10, 0, 0, "rem", 1, 16'd0);
        issue(0, 4'd1, 2'd3, 16'd120, 16'd10, 0, 0, "mulh", 1, 16'd0);
        issue(0, 4'd1, 2'd0, 16'(-300), 16'd200, 0, 0, "mul_neg", 1, 16'd5536);
        issue(0, 4'd1, 2'd3, 16'(-300), 16'd200, 0, 0, "mulh_neg", 1, 16'hFFFF);
        issue(0, 4'd1, 2'd1, 16'(-7), 16'd2, 0, 0, "div_neg", 1, 16'(-3));
        issue(0, 4'd1, 2'd2, 16'(-7), 16'd2, 0, 0, "rem_neg", 1, 16'(-1));
        issue(0, 4'd1, 2'd1, 16'd1234, 16'd0, 0, 0, "div_zero", 1, 16'hFFFF);
        issue(0, 4'd1, 2'd2, 16'd1234, 16'd0, 0, 0, "rem_zero", 1, 16'd1234);
        issue(0, 4'd1, 2'd1, 16'h8000, 16'hFFFF, 0, 0, "div_ovf", 1, 16'h8000);
        issue(0, 4'd1, 2'd2, 16'h8000, 16'hFFFF, 0, 0, "rem_ovf", 1, 16'h0000);
        issue(0, 4'd0, 2'd0, 16'd32767, 16'd0, 1, 0, "add_ovf", 1, 16'h8000);
        issue(0, 4'd0, 2'd1, 16'd120, 16'd10, 0, 1, "sub_bin", 1, 16'd109);
        issue(0, 4'd2, 2'd0, 16'd120, 16'd10, 0, 0, "and", 1, 16'd8);
        issue(0, 4'd2, 2'd2, 16'd120, 16'd10, 0, 0, "xor", 1, 16'd114);
        issue(0, 4'd3, 2'd0, 16'd120, 16'd10, 0, 0, "sll", 1, 16'hE000);
        issue(0, 4'd3, 2'd2, 16'(-128), 16'd10, 0, 0, "sra", 1, 16'hFFFF);
        issue(0, 4'd3, 2'd3, 16'h1234, 16'hFFF0, 0, 0, "rol0", 1, 16'h1234);
        issue(0, 4'd4, 2'd1, 16'd120, 16'd10, 0, 0, "slt", 1, 16'd0);
        issue(0, 4'd4, 2'd3, 16'd120, 16'd10, 0, 0, "max", 1, 16'd120);
        issue(0, 4'd10, 2'd1, 16'h1234, 16'h5678, 1, 1, "unused_op", 1, 16'd0);
        issue(1, 4'd0, 2'd0, 16'd5, 16'd6, 0, 0, "rst_on_valid", 1, 16'd11);
        for (int i = 0; i < 400; i++) begin
            issue(($urandom_range(0, 19) == 0), 4'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                  pick_operand(), pick_operand(), 1'($urandom), 1'($urandom), "rand");
        end
        repeat (3) @(posedge clk);
        #1;
        check("drain", {15'h0, (sb_q.size() != 0) || have_pend}, 16'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
